// File: rtl/car_alarm_siren_controller_pkg.sv
// Shared state codes and width helpers for the car-alarm siren controller.
package car_alarm_siren_controller_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_CONFIRM = 3'd1,
    ST_ALARM   = 3'd2,
    ST_HOLDOFF = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_e;

  // Width able to hold 0..max_val-1, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/car_alarm_siren_controller_if.sv
// Alarm-input / siren-output bundle between the alarm gate, the controller and the drivers.
interface car_alarm_siren_controller_if #(parameter int TW = 2);
  import car_alarm_siren_controller_pkg::*;

  logic               CarAlarmSignal;
  logic               DisarmKey;
  logic               SirenOn;
  logic               HornPulse;
  logic               Locked;
  logic [STATE_W-1:0] AlarmState;
  logic [TW-1:0]      TriggerCount;

  modport master (
    output CarAlarmSignal, DisarmKey,
    input  SirenOn, HornPulse, Locked, AlarmState, TriggerCount
  );

  modport slave (
    input  CarAlarmSignal, DisarmKey,
    output SirenOn, HornPulse, Locked, AlarmState, TriggerCount
  );
endinterface

// File: rtl/car_alarm_siren_controller_alarm_input_sync.sv
// Two-flop synchroniser for one asynchronous level input.
module alarm_input_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);
  logic [1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= 2'b00;
    else        r_sync <= {r_sync[0], i_async};
  end

  assign o_sync = r_sync[1];
endmodule

// File: rtl/car_alarm_siren_controller.sv
// Siren controller: debounces the alarm gate output, runs timed siren windows with a
// blinking horn, holds off between alarms and locks out after too many; disarm clears all.
module car_alarm_siren_controller
  import car_alarm_siren_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ALARM_CYCLES    = 32,
  parameter int BLINK_CYCLES    = 4,
  parameter int HOLDOFF_CYCLES  = 8,
  parameter int MAX_TRIGGERS    = 3
) (
  input logic                    clk,
  input logic                    rst_n,
  car_alarm_siren_controller_if.slave bus
);
  localparam int TW    = $clog2(MAX_TRIGGERS + 1);
  localparam int CNT_W = cnt_width(max3(DEBOUNCE_CYCLES, ALARM_CYCLES, HOLDOFF_CYCLES));
  localparam int BLK_W = cnt_width(BLINK_CYCLES);

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALARM_LAST = CNT_W'(ALARM_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_CYCLES - 1);
  localparam logic [TW-1:0]    TRIG_MAX   = TW'(MAX_TRIGGERS);

  logic             w_alarm_s;
  logic             w_key_s;
  logic             r_key_d;
  logic             r_disarm;
  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [BLK_W-1:0] r_blink;
  logic [TW-1:0]    r_tcnt;
  logic             r_siren;
  logic             r_horn;
  logic             r_locked;

  alarm_input_sync u_alarm_sync (.clk(clk), .rst_n(rst_n), .i_async(bus.CarAlarmSignal), .o_sync(w_alarm_s));
  alarm_input_sync u_key_sync   (.clk(clk), .rst_n(rst_n), .i_async(bus.DisarmKey),      .o_sync(w_key_s));

  // Registered rising-edge detect of the key gives the three-edge disarm latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_d  <= 1'b0;
      r_disarm <= 1'b0;
    end else begin
      r_key_d  <= w_key_s;
      r_disarm <= w_key_s & ~r_key_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_blink  <= '0;
      r_tcnt   <= '0;
      r_siren  <= 1'b0;
      r_horn   <= 1'b0;
      r_locked <= 1'b0;
    end else if (r_disarm) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_blink  <= '0;
      r_tcnt   <= '0;
      r_siren  <= 1'b0;
      r_horn   <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_alarm_s) begin
            r_state <= ST_CONFIRM;
            r_cnt   <= '0;
          end
        end
        ST_CONFIRM: begin
          if (!w_alarm_s) begin
            r_state <= ST_IDLE;
          end else if (r_cnt == DEB_LAST) begin
            r_state <= ST_ALARM;
            r_cnt   <= '0;
            r_blink <= '0;
            r_siren <= 1'b1;
            r_horn  <= 1'b1;
            if (r_tcnt != TRIG_MAX) r_tcnt <= r_tcnt + TW'(1);
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_ALARM: begin
          if (r_cnt == ALARM_LAST) begin
            r_cnt   <= '0;
            r_siren <= 1'b0;
            r_horn  <= 1'b0;
            if (r_tcnt == TRIG_MAX) begin
              r_state  <= ST_LOCKOUT;
              r_locked <= 1'b1;
            end else begin
              r_state <= ST_HOLDOFF;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_blink == BLINK_LAST) begin
              r_blink <= '0;
              r_horn  <= ~r_horn;
            end else begin
              r_blink <= r_blink + BLK_W'(1);
            end
          end
        end
        ST_HOLDOFF: begin
          if (r_cnt == HOLD_LAST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_LOCKOUT: begin
          r_locked <= 1'b1;
        end
        default: begin
          // Unused codes fall back to a quiet IDLE.
          r_state  <= ST_IDLE;
          r_cnt    <= '0;
          r_siren  <= 1'b0;
          r_horn   <= 1'b0;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign bus.SirenOn      = r_siren;
  assign bus.HornPulse    = r_horn;
  assign bus.Locked       = r_locked;
  assign bus.AlarmState   = r_state;
  assign bus.TriggerCount = r_tcnt;
endmodule
